ps2_move_ctrl: RTL
==================

# ps2_move_ctrl

Receive-only PS/2 keyboard front end that turns arrow-key presses into block positions for the maze drawing path. It deserialises PS/2 frames, decodes extended make/break sequences, and steps a position register by one block (8 px) per arrow make code, clamped to the 320x240 screen. It sits directly upstream of the 8x8 block drawer. `pos_x` and `pos_y` feed its bias inputs, and `move_valid` starts a redraw.

## Interface

Parameters:
- `STEP`, 8: pixels moved per key press; equals the block size.
- `X_MAX`, 312: largest legal `pos_x` (320 - STEP).
- `Y_MAX`, 232: largest legal `pos_y` (240 - STEP).
- `TIMEOUT`, 50000: clock cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).

Ports:
- `clock`, in, 1: system clock (CLOCK_50).
- `resetn`, in, 1: reset, asynchronous, active-low.
- `ps2_clk`, in, 1: raw PS/2 clock from the pad; asynchronous to `clock`.
- `ps2_dat`, in, 1: raw PS/2 data from the pad; asynchronous.
- `scan_code`, out, 8: last accepted frame byte.
- `code_valid`, out, 1: one-cycle pulse when `scan_code` updates.
- `parity_err`, out, 1: one-cycle pulse when a frame is rejected.
- `pos_x`, out, 9: block x origin, 0..X_MAX, always a multiple of STEP.
- `pos_y`, out, 8: block y origin, 0..Y_MAX, always a multiple of STEP.
- `move_valid`, out, 1: one-cycle pulse when `pos_x`/`pos_y` changed.

## Operation

**Reset.** All outputs are 0. The receiver and decoder are idle, and the synchronisers are preset to 1 (PS/2 idle level).

**Receiver.**
- `ps2_clk` and `ps2_dat` each pass through a 2-FF synchroniser.
- A falling edge is the case where the previous synced clock is 1 and the current synced clock is 0.
- On each falling edge, sample synced data into an 11-bit shift register, LSB first.
- Frame format: start (0), d0..d7, odd parity, stop (1). A 4-bit counter counts 0..10.
- On the 11th edge the frame is complete and the counter returns to 0.
- Good frame: load `scan_code` and pulse `code_valid` the next cycle.
- Bad frame: see Configuration.
- Timeout: when the counter is non-zero and TIMEOUT cycles pass with no falling edge, the counter returns to 0 and the partial frame is discarded silently.

**Decoder FSM.** It advances only on `code_valid`.
- IDLE:
  - 0xE0 goes to EXT.
  - 0xF0 goes to BRK.
  - Any other byte stays in IDLE; non-extended keys are ignored.
- EXT:
  - 0xF0 goes to EXT_BRK.
  - 0x75 (up), 0x72 (down), 0x6B (left) or 0x74 (right) issues a move, then goes to IDLE.
  - Any other byte goes to IDLE.
- BRK: any byte goes to IDLE (break of a normal key).
- EXT_BRK: any byte goes to IDLE (arrow release; no action).

**Move arithmetic.**
- up: `pos_y` -= STEP.
- down: `pos_y` += STEP.
- left: `pos_x` -= STEP.
- right: `pos_x` += STEP.
- Compute in width+1 bits. Clamp to [0, X_MAX] or [0, Y_MAX]. There is no wrap-around.
- If clamping leaves the position unchanged, there is no update and `move_valid` stays low.
- Typematic repeats arrive as repeated E0 xx make sequences, and each one moves again.

## Timing

- `code_valid` is high on the cycle after the 11th detected falling edge. The raw edge to detected edge is 3 cycles.
- For a move code, the decoder registers the command on the `code_valid` cycle. `pos_x`/`pos_y` update and `move_valid` pulses one cycle after `code_valid`.
- Back-to-back `code_valid` pulses are at least 11 PS/2 clocks apart, so the move path never overlaps.
- Reset asserted mid-frame or mid-sequence takes effect immediately: the counter and FSM clear, and the position returns to (0,0).
- `scan_code` holds its value between pulses.

## Configuration

Macro: `PS2_PARITY_CHECK_EN`.
- Defined: a frame is rejected if the start bit is not 0, the stop bit is not 1, or parity is not odd.
  - On rejection, `parity_err` pulses on the cycle `code_valid` would have.
  - `code_valid` stays low, `scan_code` is unchanged, and the FSM does not advance.
- Undefined: frames are accepted regardless of start, stop or parity. `parity_err` is tied to 0.

## Test plan

- Reset, then send frame 0x1C (parity 0, valid): `scan_code`=0x1C, `code_valid` pulses once, `pos` stays (0,0), no `move_valid`.
- From (0,0), send E0 74, then E0 72: after the first, `pos`=(8,0) with `move_valid`; after the second, `pos`=(8,8) with `move_valid`.
- From (0,0), send E0 6B (left): `pos` stays (0,0) and `move_valid` stays low. After 39 E0 74 sequences, `pos_x`=312; a 40th gives no change.
- Send E0 74 then E0 F0 74 (press and release): exactly one `move_valid`, `pos_x`=8.
- With `PS2_PARITY_CHECK_EN`, send 0x74 with the wrong parity bit: `parity_err` pulses and there is no `code_valid`. Without the macro, the same frame gives `code_valid` and `scan_code`=0x74.
- Send 5 bits, then idle for 50000 cycles, then send a full 0x1C frame: `scan_code`=0x1C with no error. Assert `resetn`=0 mid-frame: all outputs go to 0 immediately.

Source files
------------

// File: rtl/ps2_move_ctrl.sv
// rtl/ps2_move_ctrl.sv - PS/2 arrow-key receiver stepping a clamped block position
// Optional frame checking (start/stop/odd parity) under PS2_PARITY_CHECK_EN.
module ps2_move_ctrl #(
    parameter int STEP    = 8,
    parameter int X_MAX   = 312,
    parameter int Y_MAX   = 232,
    parameter int TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       parity_err,
    output logic [8:0] pos_x,
    output logic [7:0] pos_y,
    output logic       move_valid
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    shift_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    scan_code_q;
    logic          code_valid_q, parity_err_q, move_valid_q;
    logic [8:0]    pos_x_q, pos_x_d;
    logic [7:0]    pos_y_q, pos_y_d;
    state_t        state_q;

    logic fall, frame_last, frame_ok, timed_out, is_arrow, do_move;
    logic [9:0] x_sum, x_dif;
    logic [8:0] y_sum, y_dif;

    assign fall       = clk_prev_q & ~clk_sync_q;
    assign frame_last = fall && (bit_cnt_q == 4'd10);
    assign timed_out  = (bit_cnt_q != 4'd0) && !fall && (to_cnt_q == TW'(TIMEOUT - 1));

    // The completed frame is {stop, parity, d7..d0, start} = {dat_sync_q, shift_q}.
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ~shift_q[0] & dat_sync_q & (^shift_q[9:1]);
`else
    assign frame_ok = 1'b1;
`endif

    assign x_sum = {1'b0, pos_x_q} + 10'(STEP);
    assign x_dif = {1'b0, pos_x_q} - 10'(STEP);
    assign y_sum = {1'b0, pos_y_q} + 9'(STEP);
    assign y_dif = {1'b0, pos_y_q} - 9'(STEP);

    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        is_arrow = 1'b1;
        case (scan_code_q)
            8'h75:   pos_y_d = y_dif[8] ? 8'd0 : y_dif[7:0];
            8'h72:   pos_y_d = (y_sum > 9'(Y_MAX)) ? 8'(Y_MAX) : y_sum[7:0];
            8'h6B:   pos_x_d = x_dif[9] ? 9'd0 : x_dif[8:0];
            8'h74:   pos_x_d = (x_sum > 10'(X_MAX)) ? 9'(X_MAX) : x_sum[8:0];
            default: is_arrow = 1'b0;
        endcase
    end

    assign do_move = code_valid_q && (state_q == S_EXT) && is_arrow &&
                     ((pos_x_d != pos_x_q) || (pos_y_d != pos_y_q));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            scan_code_q  <= 8'd0;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            state_q      <= S_IDLE;
            pos_x_q      <= 9'd0;
            pos_y_q      <= 8'd0;
            move_valid_q <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk;
            clk_sync_q   <= clk_meta_q;
            clk_prev_q   <= clk_sync_q;
            dat_meta_q   <= ps2_dat;
            dat_sync_q   <= dat_meta_q;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;

            if (fall) begin
                shift_q   <= {dat_sync_q, shift_q[9:1]};
                bit_cnt_q <= frame_last ? 4'd0 : bit_cnt_q + 4'd1;
            end else if (timed_out) begin
                bit_cnt_q <= 4'd0;
            end

            if (fall || bit_cnt_q == 4'd0 || timed_out)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + TW'(1);

            if (frame_last) begin
                if (frame_ok) begin
                    scan_code_q  <= shift_q[8:1];
                    code_valid_q <= 1'b1;
                end else begin
                    parity_err_q <= 1'b1;
                end
            end

            if (code_valid_q) begin
                case (state_q)
                    S_IDLE:  state_q <= (scan_code_q == 8'hE0) ? S_EXT :
                                        (scan_code_q == 8'hF0) ? S_BRK : S_IDLE;
                    S_EXT:   state_q <= (scan_code_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end

            move_valid_q <= do_move;
            if (do_move) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
            end
        end
    end

    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign parity_err = parity_err_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign move_valid = move_valid_q;
endmodule
